// File: rtl/onehot_decoder_8_if.sv
// onehot_decoder_8_if: index handshake and decoded-output bundle for onehot_decoder_8
interface onehot_decoder_8_if;
    logic       en;
    logic [2:0] in_idx;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_onehot;
    logic       out_valid;
    logic       busy;
    logic [7:0] accept_cnt;
    modport master (
        output en, in_idx, in_valid,
        input  in_ready, out_onehot, out_valid, busy, accept_cnt
    );
    modport slave (
        input  en, in_idx, in_valid,
        output in_ready, out_onehot, out_valid, busy, accept_cnt
    );
endinterface

// File: rtl/onehot_decoder_8.sv
// onehot_decoder_8: handshaked 3-to-8 decoder holding each index for HOLD_CYCLES cycles
module onehot_decoder_8 #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    onehot_decoder_8_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t     state;
    logic [7:0] hold_cnt;
    logic       accept;
    assign bus.in_ready = bus.en && (state == IDLE || (state == HOLD && hold_cnt == 8'd1));
    assign accept = bus.in_valid && bus.in_ready;
    // accept loads a new hold (also on the last hold cycle for gapless streaming); en low or expiry clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            hold_cnt       <= 8'd0;
            bus.out_onehot <= 8'h00;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.accept_cnt <= 8'd0;
        end else if (accept) begin
            state          <= HOLD;
            hold_cnt       <= 8'(HOLD_CYCLES);
            bus.out_onehot <= 8'h01 << bus.in_idx;
            bus.out_valid  <= 1'b1;
            bus.busy       <= 1'b1;
            bus.accept_cnt <= (bus.accept_cnt == 8'hFF) ? 8'hFF : bus.accept_cnt + 8'd1;
        end else if (state == HOLD && (!bus.en || hold_cnt == 8'd1)) begin
            state          <= IDLE;
            hold_cnt       <= 8'd0;
            bus.out_onehot <= 8'h00;
            bus.out_valid  <= 1'b0;
            bus.busy       <= 1'b0;
        end else if (state == HOLD) begin
            hold_cnt <= hold_cnt - 8'd1;
        end
    end
endmodule

// File: tb/tb_onehot_decoder_8.sv
// tb_onehot_decoder_8: scoreboard bench driving a HOLD_CYCLES=4 and a HOLD_CYCLES=1 decoder in parallel
module tb_onehot_decoder_8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = 3'd0;
    int         vectors = 0;
    int         miscompares = 0;
    int         hc[2] = '{4, 1};
    logic [7:0] q[2][$];
    int         cnt[2] = '{0, 0};
    logic [7:0] oh[2], ac[2];
    logic       ov[2], bz[2], rdy[2];

    always #5 clk = ~clk;

    onehot_decoder_8_if i4 ();
    onehot_decoder_8_if i1 ();
    assign i4.en = en;
    assign i4.in_valid = in_valid;
    assign i4.in_idx = in_idx;
    assign i1.en = en;
    assign i1.in_valid = in_valid;
    assign i1.in_idx = in_idx;
    assign oh[0] = i4.out_onehot;
    assign ov[0] = i4.out_valid;
    assign bz[0] = i4.busy;
    assign ac[0] = i4.accept_cnt;
    assign rdy[0] = i4.in_ready;
    assign oh[1] = i1.out_onehot;
    assign ov[1] = i1.out_valid;
    assign bz[1] = i1.busy;
    assign ac[1] = i1.accept_cnt;
    assign rdy[1] = i1.in_ready;

    onehot_decoder_8 #(.HOLD_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
    onehot_decoder_8 #(.HOLD_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", name, hc[d], $time, act, exp);
        end
    endtask

    // Reference model: each accept schedules HOLD_CYCLES output cycles of the decoded value;
    // the block is ready exactly when nothing is left scheduled beyond the current cycle.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (!en) q[d].delete();
                else if (in_valid && q[d].size() == 0) begin
                    for (int k = 0; k < hc[d]; k++) q[d].push_back(8'h01 << in_idx);
                    cnt[d] = (cnt[d] == 255) ? 255 : cnt[d] + 1;
                end
            end
        end
    end

    // Monitor: one scheduled value consumed per cycle, compared away from the active edge
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [7:0] e;
            e = (q[d].size() != 0) ? q[d].pop_front() : 8'h00;
            chk("onehot", d, oh[d], e);
            chk("valid", d, {7'd0, ov[d]}, {7'd0, e != 8'h00});
            chk("busy", d, {7'd0, bz[d]}, {7'd0, e != 8'h00});
            chk("accept_cnt", d, ac[d], 8'(cnt[d]));
            chk("in_ready", d, {7'd0, rdy[d]}, {7'd0, en && q[d].size() == 0});
        end
    end

    task automatic step(input logic e, input logic v, input logic [2:0] i);
        en = e;
        in_valid = v;
        in_idx = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] seq[3];
        seq = '{3'd7, 3'd0, 3'd3};
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 1, 3'd5);
        repeat (6) step(1, 0, 3'd0);
        for (int c = 0; c < 12; c++) step(1, 1, seq[c / 4]);
        repeat (5) step(1, 0, 3'd0);
        for (int c = 0; c < 8; c++) step(1, 1, 3'(c));
        repeat (5) step(1, 0, 3'd0);
        step(1, 1, 3'd6);
        step(1, 0, 3'd0);
        step(0, 1, 3'd1);
        step(0, 1, 3'd2);
        repeat (3) step(1, 0, 3'd0);
        step(1, 1, 3'd4);
        #1 rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        cnt = '{0, 0};
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_onehot", d, oh[d], 8'h00);
            chk("async_rst_valid", d, {7'd0, ov[d] | bz[d]}, 8'h00);
            chk("async_rst_cnt", d, ac[d], 8'h00);
        end
        step(0, 0, 3'd0);
        rst_n = 1'b1;
        step(1, 1, 3'd2);
        repeat (4) step(1, 0, 3'd0);
        for (int c = 0; c < 300; c++) step(1, 1, 3'($urandom_range(0, 7)));
        for (int c = 0; c < 400; c++)
            step(($urandom % 8) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
        repeat (6) step(1, 0, 3'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
